// File: rtl/hazard_unit_mc.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Also tracks the multi-cycle mult/div unit so that only HI/LO consumers
// and a second mult/div are held while it is busy.

// Forwarding select for a single source operand.
// sel = 2'b10 on an M-stage match, 2'b01 on a W-stage match, else 2'b00.
// M wins over W because it holds the younger result.
module hazard_fwd_sel #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] src,
   input  logic             regwriteM,
   input  logic [REG_W-1:0] writeregM,
   input  logic             regwriteW,
   input  logic [REG_W-1:0] writeregW,
   output logic [1:0]       sel
);

   logic src_nz;
   logic hit_m;
   logic hit_w;

   assign src_nz = (src != '0);
   assign hit_m  = src_nz && regwriteM && (src == writeregM);
   assign hit_w  = src_nz && regwriteW && (src == writeregW);

   // Priority encode the two matches into the mux select.
   always_comb begin
      sel = 2'b00;
      if (hit_m)      sel = 2'b10;
      else if (hit_w) sel = 2'b01;
   end

endmodule

module hazard_unit_mc #(
   parameter int          REG_W    = 5,
   parameter int          MD_LAT   = 32,
   parameter int          MDCNT_W  = 6,
   parameter logic [2:0]  LOAD_SRC = 3'b011,
   parameter int          PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        branchD,
   input  logic [2:0]        wbsrcE,
   input  logic [2:0]        wbsrcM,
   input  logic              regwriteE,
   input  logic              regwriteM,
   input  logic              regwriteW,
   input  logic [REG_W-1:0]  rsD,
   input  logic [REG_W-1:0]  rtD,
   input  logic [REG_W-1:0]  rsE,
   input  logic [REG_W-1:0]  rtE,
   input  logic [REG_W-1:0]  writeregE,
   input  logic [REG_W-1:0]  writeregM,
   input  logic [REG_W-1:0]  writeregW,
   input  logic              mdstartE,
   input  logic              mdstartD,
   input  logic              mdreadD,
   output logic              stallF,
   output logic              stallD,
   output logic              flushE,
   output logic              forwardAD,
   output logic              forwardBD,
   output logic [1:0]        forwardAE,
   output logic [1:0]        forwardBE,
   output logic              mdbusy,
   output logic              mddone,
   output logic [PERF_W-1:0] stallcnt
);

   localparam int NUM_SRC = 4;
   localparam logic [MDCNT_W-1:0] CNT_LOAD = MDCNT_W'(MD_LAT - 1);

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // ---------------------------------------------------------------
   // Forwarding: one selector per source operand.
   // Index order: 0 rsD, 1 rtD, 2 rsE, 3 rtE.
   // ---------------------------------------------------------------
   logic [NUM_SRC-1:0][REG_W-1:0] fwd_src;
   logic [NUM_SRC-1:0][1:0]       fwd_sel;

   assign fwd_src = {rtE, rsE, rtD, rsD};

   generate
      for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
         hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
            .src       (fwd_src[g]),
            .regwriteM (regwriteM),
            .writeregM (writeregM),
            .regwriteW (regwriteW),
            .writeregW (writeregW),
            .sel       (fwd_sel[g])
         );
      end
   endgenerate

   // D-stage forwarding only ever comes from M (branch compare in D).
   assign forwardAD = fwd_sel[0][1];
   assign forwardBD = fwd_sel[1][1];
   assign forwardAE = fwd_sel[2];
   assign forwardBE = fwd_sel[3];

   // ---------------------------------------------------------------
   // Stall sources
   // ---------------------------------------------------------------
   logic lwstall;
   logic brstall;
   logic mdstall;
   logic br_dep_e;
   logic br_dep_m;
   logic stall_any;

   // Load-use: E-stage load feeding either D source.
   assign lwstall = (wbsrcE == LOAD_SRC) && (rtE != '0) &&
                    ((rtE == rsD) || (rtE == rtD));

   // Branch in D needs a value still being produced in E, or a load in M.
   assign br_dep_e = regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));
   assign br_dep_m = (wbsrcM == LOAD_SRC) && (writeregM != '0) &&
                     ((writeregM == rsD) || (writeregM == rtD));
   assign brstall  = (branchD != 2'b00) && (br_dep_e || br_dep_m);

   // Only HI/LO readers and a second mult/div wait on the busy unit.
   assign mdstall  = mdbusy && (mdreadD || mdstartD);

   assign stall_any = !reset && (lwstall || brstall || mdstall);
   assign stallF    = stall_any;
   assign stallD    = stall_any;
   assign flushE    = stall_any;

   // ---------------------------------------------------------------
   // Mult/div tracker
   // ---------------------------------------------------------------
   md_state_t          state, state_nx;
   logic [MDCNT_W-1:0] cnt, cnt_nx;

   // State and countdown registers; reset abandons any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and countdown; a start on the done cycle chains straight on.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         MD_IDLE: begin
            if (mdstartE) begin
               state_nx = MD_BUSY;
               cnt_nx   = CNT_LOAD;
            end
         end
         MD_BUSY: begin
            if (cnt == '0) begin
               if (mdstartE) begin
                  cnt_nx = CNT_LOAD;
               end else begin
                  state_nx = MD_IDLE;
               end
            end else begin
               cnt_nx = cnt - MDCNT_W'(1);
            end
         end
         default: begin
            state_nx = MD_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign mdbusy = (state == MD_BUSY);
   assign mddone = (state == MD_BUSY) && (cnt == '0);

   // ---------------------------------------------------------------
   // Stall performance counter, saturating at all-ones.
   // ---------------------------------------------------------------
   // Count every cycle the decode register is held.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallcnt <= '0;
      end else if (stallD && (stallcnt != '1)) begin
         stallcnt <= stallcnt + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MD_LAT=4, PERF_W=4 build).
module tb_hazard_unit_mc;

   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       branchD;
   logic [2:0]       wbsrcE, wbsrcM;
   logic             regwriteE, regwriteM, regwriteW;
   logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic             mdstartE, mdstartD, mdreadD;
   logic             stallF, stallD, flushE, forwardAD, forwardBD;
   logic [1:0]       forwardAE, forwardBE;
   logic             mdbusy, mddone;
   logic [3:0]       stallcnt;

   int tests = 0;
   int fails = 0;

   hazard_unit_mc #(
      .REG_W(REG_W), .MD_LAT(4), .MDCNT_W(3), .LOAD_SRC(3'b011), .PERF_W(4)
   ) dut (
      .clk(clk), .reset(reset), .branchD(branchD), .wbsrcE(wbsrcE), .wbsrcM(wbsrcM),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .mdstartE(mdstartE), .mdstartD(mdstartD), .mdreadD(mdreadD),
      .stallF(stallF), .stallD(stallD), .flushE(flushE),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .mdbusy(mdbusy), .mddone(mddone), .stallcnt(stallcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_in();
      branchD = 0; wbsrcE = 0; wbsrcM = 0;
      regwriteE = 0; regwriteM = 0; regwriteW = 0;
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      writeregE = 0; writeregM = 0; writeregW = 0;
      mdstartE = 0; mdstartD = 0; mdreadD = 0;
   endtask

   task automatic chk_stall(input string tag, input logic e);
      chk({tag, ".stallF"}, 32'(stallF), 32'(e));
      chk({tag, ".stallD"}, 32'(stallD), 32'(e));
      chk({tag, ".flushE"}, 32'(flushE), 32'(e));
   endtask

   initial begin
      // ---- reset ----
      clear_in();
      reset = 1'b1;
      tick(2);
      chk("rst.mdbusy", 32'(mdbusy), 0);
      chk("rst.mddone", 32'(mddone), 0);
      chk("rst.stallcnt", 32'(stallcnt), 0);
      wbsrcE = 3'b011; rtE = 8; rsD = 8;   // load-use present while in reset
      #1 chk_stall("rst.gate", 1'b0);
      clear_in();
      reset = 1'b0;
      tick();
      chk_stall("idle", 1'b0);
      chk("idle.fAE", 32'(forwardAE), 0);

      // ---- 1: load-use ----
      wbsrcE = 3'b011; rtE = 8; rsD = 8;
      #1 chk_stall("lw.rs", 1'b1);
      tick();                               // one stalled cycle counted
      chk("lw.cnt1", 32'(stallcnt), 1);
      clear_in();
      wbsrcE = 3'b011; rtE = 8; rtD = 8; rsD = 1;
      #1 chk("lw.rt", 32'(stallD), 1);
      rtE = 0; rtD = 0; rsD = 0;
      #1 chk("lw.r0", 32'(stallD), 0);
      wbsrcE = 3'b001; rtE = 8; rsD = 8;
      #1 chk("lw.notload", 32'(stallD), 0);
      clear_in();

      // ---- 2: branch ----
      branchD = 2'b01; rsD = 5; regwriteE = 1; writeregE = 5;
      #1 chk("br.e", 32'(stallD), 1);
      branchD = 2'b00;
      #1 chk("br.nobr", 32'(stallD), 0);
      clear_in();
      branchD = 2'b10; wbsrcM = 3'b011; writeregM = 7; rtD = 7; rsD = 2;
      #1 chk("br.mload", 32'(stallD), 1);
      branchD = 2'b00;
      #1 chk("br.mload.gate", 32'(stallD), 0);
      clear_in();
      branchD = 2'b01; regwriteE = 1; writeregE = 0; rsD = 0;
      #1 chk("br.r0", 32'(stallD), 0);
      clear_in();

      // ---- 3: forwarding ----
      rsE = 3; regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3;
      #1 chk("fwd.AE.M", 32'(forwardAE), 2);
      regwriteM = 0;
      #1 chk("fwd.AE.W", 32'(forwardAE), 1);
      regwriteM = 1; rsE = 0;
      #1 chk("fwd.AE.r0", 32'(forwardAE), 0);
      rtE = 4; writeregW = 4; writeregM = 9;
      #1 chk("fwd.BE.W", 32'(forwardBE), 1);
      rsD = 9; rtD = 4;
      #1 chk("fwd.AD", 32'(forwardAD), 1);
      chk("fwd.BD.Wonly", 32'(forwardBD), 0);
      rtD = 9;
      #1 chk("fwd.BD", 32'(forwardBD), 1);
      chk_stall("fwd.nostall", 1'b0);
      clear_in();

      // ---- 4: mult/div timing ----
      mdstartE = 1;
      tick();                               // busy cycle 1
      mdstartE = 0;
      chk("md.busy1", 32'(mdbusy), 1);
      chk("md.done1", 32'(mddone), 0);
      rsD = 6; rtD = 7;                     // independent add
      #1 chk("md.add", 32'(stallD), 0);
      mdreadD = 1;                          // mflo
      #1 chk("md.mflo1", 32'(stallD), 1);
      tick();                               // busy cycle 2
      mdreadD = 0; mdstartD = 1;
      #1 chk("md.second", 32'(stallD), 1);
      mdstartD = 0; mdreadD = 1;
      tick();                               // busy cycle 3
      chk("md.done3", 32'(mddone), 0);
      tick();                               // busy cycle 4
      chk("md.busy4", 32'(mdbusy), 1);
      chk("md.done4", 32'(mddone), 1);
      chk("md.mflo4", 32'(stallD), 1);
      tick();
      chk("md.idle", 32'(mdbusy), 0);
      chk("md.done5", 32'(mddone), 0);
      chk("md.mflo5", 32'(stallD), 0);
      chk("md.cnt", 32'(stallcnt), 5);      // 1 from load-use + 4 mflo cycles
      clear_in();

      // restart on done cycle
      mdstartE = 1;
      tick();
      mdstartE = 0;
      tick(3);
      chk("rs.done", 32'(mddone), 1);
      mdstartE = 1;
      tick();
      mdstartE = 0;
      chk("rs.busy", 32'(mdbusy), 1);
      chk("rs.done0", 32'(mddone), 0);
      tick(3);
      chk("rs.done2", 32'(mddone), 1);
      tick();
      chk("rs.idle", 32'(mdbusy), 0);

      // ---- 5: reset mid-operation ----
      mdstartE = 1;
      tick();                               // cnt=3
      mdstartE = 0;
      tick();                               // cnt=2
      chk("mr.busy", 32'(mdbusy), 1);
      reset = 1; mdreadD = 1;
      #1 chk("mr.gate", 32'(stallD), 0);
      tick();
      chk("mr.busy0", 32'(mdbusy), 0);
      chk("mr.cnt0", 32'(stallcnt), 0);
      reset = 0;
      #1 chk("mr.mflo", 32'(stallD), 0);
      tick();
      chk("mr.done", 32'(mddone), 0);
      chk("mr.idle", 32'(mdbusy), 0);
      clear_in();

      // ---- 6: saturating counter ----
      wbsrcE = 3'b011; rtE = 8; rsD = 8;
      tick(3);
      chk("sat.3", 32'(stallcnt), 3);
      tick(12);
      chk("sat.15", 32'(stallcnt), 15);
      tick(4);                              // 19 = 2**4+3 stalled cycles total
      chk("sat.19", 32'(stallcnt), 15);
      clear_in();
      tick();
      chk("sat.hold", 32'(stallcnt), 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
